// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: capture sequencer for the GPIO logic analyzer.
// Waits for a masked-pattern trigger on divided sample ticks, records a
// fixed-length burst into an internal RAM, then streams it out over
// valid/ready. The host sees busy/triggered status and a done pulse.
module la_capture_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int DIV_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          reads,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [DIV_W-1:0]          clk_div,
  input  logic [WIDTH-1:0]          trig_mask,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [$clog2(DEPTH)-1:0]  capture_len,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      triggered,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);
  // Lengths carry one extra bit so that a full-RAM capture (DEPTH) is representable.
  localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t           state;

  // Configuration latched on an accepted arm.
  logic [DIV_W-1:0] div_l;
  logic [WIDTH-1:0] mask_l;
  logic [WIDTH-1:0] value_l;
  logic [AW:0]      len_l;

  logic [DIV_W-1:0] div_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;

  logic [WIDTH-1:0] ram [DEPTH];

  logic             tick;
  logic             trig_hit;
  logic             last_wr;
  logic             last_rd;
  logic             wr_en;
  logic [AW:0]      len_m1;

  // Sample ticks exist only while waiting for the trigger or recording.
  assign tick     = ((state == ARMED) || (state == CAPTURE)) && (div_cnt == div_l);
  assign trig_hit = ((reads & mask_l) == (value_l & mask_l));
  assign len_m1   = len_l - LEN_ONE;
  assign last_wr  = ({1'b0, wr_ptr} == len_m1);
  assign last_rd  = ({1'b0, rd_ptr} == len_m1);
  assign rd_next  = rd_ptr + 1'b1;
  assign busy     = (state != IDLE);

  // The trigger sample goes to RAM[0] (wr_ptr is 0 in ARMED); every later tick
  // in CAPTURE appends one sample. Aborted writes are dropped.
  assign wr_en = tick && !abort &&
                 (((state == ARMED) && trig_hit) || (state == CAPTURE));

  // Sample RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_ptr] <= reads;
    end
  end

  // Capture sequencer: state, divider, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_l     <= '0;
      mask_l    <= '0;
      value_l   <= '0;
      len_l     <= '0;
      div_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over everything, including an arm in IDLE.
        state     <= IDLE;
        div_cnt   <= '0;
        out_valid <= 1'b0;
        triggered <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            div_cnt <= '0;
            if (arm) begin
              div_l   <= clk_div;
              mask_l  <= trig_mask;
              value_l <= trig_value;
              len_l   <= (capture_len == '0) ? LEN_FULL : {1'b0, capture_len};
              wr_ptr  <= '0;
              rd_ptr  <= '0;
              state   <= ARMED;
            end
          end

          ARMED: begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick && trig_hit) begin
              wr_ptr    <= wr_ptr + 1'b1;
              triggered <= 1'b1;
              if (len_l == LEN_ONE) begin
                state   <= DRAIN;
                div_cnt <= '0;
              end else begin
                state <= CAPTURE;
              end
            end
          end

          CAPTURE: begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              // wr_ptr may wrap to 0 after a full-RAM capture; it is unused afterwards.
              wr_ptr <= wr_ptr + 1'b1;
              if (last_wr) begin
                state   <= DRAIN;
                div_cnt <= '0;
              end
            end
          end

          DRAIN: begin
            div_cnt <= '0;
            if (!out_valid) begin
              // First cycle in DRAIN: prefetch RAM[0] so valid rises next cycle.
              out_data  <= ram[rd_ptr];
              out_valid <= 1'b1;
            end else if (out_ready) begin
              if (last_rd) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
                triggered <= 1'b0;
                state     <= IDLE;
              end else begin
                // Fetch the following entry in the handshake cycle for gapless beats.
                rd_ptr   <= rd_next;
                out_data <= ram[rd_next];
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Testbench for la_capture_ctrl: directed table of capture scenarios,
// randomized captures against a tick/trigger reference model, and
// hand-written abort / arm-while-busy / reset sequences.
module tb_la_capture_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int DIV_W = 16;
  localparam int MAXC  = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  reads;
  logic              arm;
  logic              abort;
  logic [DIV_W-1:0]  clk_div;
  logic [WIDTH-1:0]  trig_mask;
  logic [WIDTH-1:0]  trig_value;
  logic [7:0]        capture_len;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              triggered;
  logic              done;

  always #5 clk = ~clk;

  la_capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .reads       (reads),
    .arm         (arm),
    .abort       (abort),
    .clk_div     (clk_div),
    .trig_mask   (trig_mask),
    .trig_value  (trig_value),
    .capture_len (capture_len),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Per-run record: hist[j] is the pin value presented for edge j after the arm edge.
  logic [15:0] hist [0:MAXC];
  logic [15:0] beats [$];
  int trg_first, val_first, done_j, last_fire_j, end_j;

  typedef struct {
    logic [15:0] div;
    logic [15:0] mask;
    logic [15:0] val;
    logic [7:0]  len;
    logic [15:0] base;
    logic [15:0] stp;
    int          rpat;
    logic [15:0] exp_first;
    logic [15:0] exp_step;
    int          exp_n;
    int          exp_trig;
    int          exp_valid;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_r();
    reads = 16'($urandom);
    step();
  endtask

  // One full capture: arm, drive pins and out_ready each cycle, collect beats
  // until done (bounded), and check stall stability and done timing.
  task automatic run_capture(input logic [15:0] div, input logic [15:0] mask,
                             input logic [15:0] val, input logic [7:0] len,
                             input bit rnd, input logic [15:0] base,
                             input logic [15:0] stp, input int rpat);
    int j;
    int want_n;
    bit fin, prev_stall, rdy;
    logic [15:0] prev_data, rv;
    want_n = (len == 0) ? DEPTH : int'(len);
    clk_div = div; trig_mask = mask; trig_value = val; capture_len = len;
    arm = 1'b1; out_ready = 1'b0; reads = 16'($urandom);
    step();
    arm = 1'b0;
    clk_div = 16'($urandom_range(7)); trig_mask = 16'($urandom);
    trig_value = 16'($urandom); capture_len = 8'($urandom);
    beats.delete();
    trg_first = -1; val_first = -1; done_j = -1; last_fire_j = -1;
    prev_stall = 1'b0; prev_data = '0; fin = 1'b0; j = 0;
    while (!fin && j < MAXC - 1) begin
      if (j > 0) begin
        if (triggered === 1'b1 && trg_first < 0) trg_first = j;
        if (out_valid === 1'b1 && val_first < 0) val_first = j;
        if (prev_stall) begin
          chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
          chk("stall_data_hold", {16'd0, out_data}, {16'd0, prev_data});
        end
        if (done === 1'b1) begin
          done_j = j;
          fin = 1'b1;
        end
      end
      if (!fin) begin
        if (rnd)
          rv = ($urandom_range(3) == 0) ? ((val & mask) | (16'($urandom) & ~mask))
                                        : 16'($urandom);
        else
          rv = 16'(base + stp * j);
        hist[j+1] = rv;
        reads = rv;
        case (rpat)
          0:       rdy = 1'b1;
          1:       rdy = ((j % 4) == 0) || ((j % 4) == 3);
          default: rdy = 1'($urandom_range(1));
        endcase
        out_ready = rdy;
        arm = 1'b0;
        if (out_valid && rdy) begin
          beats.push_back(out_data);
          last_fire_j = j + 1;
          if (rnd && beats.size() == want_n) arm = 1'b1;
        end
        prev_stall = out_valid && !rdy;
        prev_data = out_data;
        step();
        j++;
      end
    end
    arm = 1'b0;
    end_j = j;
    if (!fin) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_at_last_beat", done_j, last_fire_j);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("valid_low_after_done", {31'd0, out_valid}, 32'd0);
      chk("trig_low_after_done", {31'd0, triggered}, 32'd0);
    end
    out_ready = 1'b0;
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("still_idle", {31'd0, busy}, 32'd0);
    chk("beat_count", beats.size(), want_n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen, cnt, d, tj, m, len_n;
    logic [15:0] d0, rmask, rval;
    logic [7:0]  rlen;

    vt[0] = '{16'd0, 16'h0000, 16'h0000, 8'd4, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 16'hFFFF, 4,   1,  5};
    vt[1] = '{16'd0, 16'h00FF, 16'h0042, 8'd3, 16'h0100, 16'h0001, 0, 16'h0142, 16'h0001, 3,   67, 70};
    vt[2] = '{16'd3, 16'h0000, 16'h0000, 8'd2, 16'h0001, 16'h0001, 0, 16'h0004, 16'h0004, 2,   4,  9};
    vt[3] = '{16'd0, 16'h0000, 16'h0000, 8'd0, 16'h1000, 16'h0003, 1, 16'h1000, 16'h0003, 256, 1,  257};
    vt[4] = '{16'd2, 16'h0000, 16'h0000, 8'd1, 16'h0055, 16'h0007, 2, 16'h0063, 16'h0000, 1,   3,  4};
    vt[5] = '{16'd2, 16'h000F, 16'h0005, 8'd2, 16'h0001, 16'h0001, 0, 16'h0015, 16'h0003, 2,   21, 25};

    // Reset, with arm held during reset
    rst = 1'b1; arm = 1'b1; abort = 1'b0; out_ready = 1'b0; reads = '0;
    clk_div = '0; trig_mask = '0; trig_value = '0; capture_len = 8'd4;
    repeat (5) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_triggered", {31'd0, triggered}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; arm = 1'b0;
    step();
    chk("idle_after_rst_arm", {31'd0, busy}, 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_capture(vt[i].div, vt[i].mask, vt[i].val, vt[i].len, 1'b0,
                  vt[i].base, vt[i].stp, vt[i].rpat);
      chk($sformatf("vec%0d_trig_cycle", i), trg_first, vt[i].exp_trig);
      chk($sformatf("vec%0d_valid_cycle", i), val_first, vt[i].exp_valid);
      for (int k = 0; k < beats.size() && k < vt[i].exp_n; k++)
        chk($sformatf("vec%0d_beat%0d", i, k), {16'd0, beats[k]},
            {16'd0, 16'(vt[i].exp_first + vt[i].exp_step * k)});
    end

    // Randomized captures against the tick/trigger model
    for (int r = 0; r < 8; r++) begin
      d     = $urandom_range(3);
      rmask = 16'($urandom) & 16'h0F0F;
      rval  = 16'($urandom);
      rlen  = (r == 3) ? 8'd0 : 8'($urandom_range(1, 40));
      len_n = (rlen == 0) ? DEPTH : int'(rlen);
      run_capture(16'(d), rmask, rval, rlen, 1'b1, 16'd0, 16'd0, 2);
      // Ticks fall on edges that are multiples of (div+1); the first matching
      // tick triggers and the next len-1 ticks are recorded.
      tj = -1; m = 1;
      while ((d + 1) * m < end_j && tj < 0) begin
        if (((hist[(d + 1) * m] ^ rval) & rmask) == 16'd0) tj = (d + 1) * m;
        m++;
      end
      chk($sformatf("rnd%0d_trig_cycle", r), trg_first, tj);
      if (tj >= 0) begin
        chk($sformatf("rnd%0d_valid_cycle", r), val_first, tj + (len_n - 1) * (d + 1) + 1);
        for (int k = 0; k < beats.size() && k < len_n; k++)
          chk($sformatf("rnd%0d_beat%0d", r, k), {16'd0, beats[k]},
              {16'd0, hist[tj + k * (d + 1)]});
      end
    end

    // arm and abort together in IDLE
    arm = 1'b1; abort = 1'b1; step_r();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", {31'd0, busy}, 32'd0);

    // Abort during CAPTURE
    clk_div = '0; trig_mask = '0; capture_len = 8'd10; out_ready = 1'b1;
    arm = 1'b1; step_r(); arm = 1'b0;
    step_r(); step_r();
    chk("capture_busy", {31'd0, busy}, 32'd1);
    chk("capture_triggered", {31'd0, triggered}, 32'd1);
    abort = 1'b1; step_r(); abort = 1'b0;
    chk("abort_cap_busy", {31'd0, busy}, 32'd0);
    chk("abort_cap_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_cap_trig", {31'd0, triggered}, 32'd0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1 || out_valid === 1'b1) seen++;
      step_r();
    end
    chk("abort_cap_no_done", seen, 0);

    // arm pulsed during DRAIN does not restart the capture
    capture_len = 8'd3; out_ready = 1'b0;
    arm = 1'b1; step_r(); arm = 1'b0;
    for (int k = 0; k < 50 && out_valid !== 1'b1; k++) step_r();
    chk("drain_valid", {31'd0, out_valid}, 32'd1);
    d0 = out_data;
    arm = 1'b1; capture_len = 8'd7; step_r(); arm = 1'b0;
    chk("arm_in_drain_busy", {31'd0, busy}, 32'd1);
    chk("arm_in_drain_valid", {31'd0, out_valid}, 32'd1);
    chk("arm_in_drain_data", {16'd0, out_data}, {16'd0, d0});
    out_ready = 1'b1; cnt = 0;
    for (int k = 0; k < 50 && done !== 1'b1; k++) begin
      if (out_valid === 1'b1) cnt++;
      step_r();
    end
    chk("drain_done_seen", {31'd0, done}, 32'd1);
    chk("drain_beats_after_arm", cnt, 3);
    step_r();
    chk("no_restart_after_drain", {31'd0, busy}, 32'd0);

    // Abort during DRAIN
    capture_len = 8'd5; out_ready = 1'b1;
    arm = 1'b1; step_r(); arm = 1'b0;
    for (int k = 0; k < 50 && out_valid !== 1'b1; k++) step_r();
    chk("drain2_valid", {31'd0, out_valid}, 32'd1);
    step_r(); step_r();
    abort = 1'b1; step_r(); abort = 1'b0;
    chk("abort_drain_busy", {31'd0, busy}, 32'd0);
    chk("abort_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_drain_done", {31'd0, done}, 32'd0);
    chk("abort_drain_trig", {31'd0, triggered}, 32'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1 || out_valid === 1'b1) seen++;
      step_r();
    end
    chk("abort_drain_quiet", seen, 0);

    // Reset mid-capture
    capture_len = 8'd20; arm = 1'b1; step_r(); arm = 1'b0;
    step_r(); step_r();
    rst = 1'b1; step_r(); rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_trig", {31'd0, triggered}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
